adc_capture: RTL
================

# adc_capture

Parametrised ADC capture front-end for the PSRAM acquisition path. Detects ADC clock falling edges inside the `clk_PSRAM` domain and discards the ADC pipeline-latency samples after enable. Optionally decimates, then packs several samples per word into a small FIFO. The FIFO feeds the PSRAM write controller over a valid/ready handshake, with sticky overflow and out-of-range flags.

## Interface
Parameters:
- `ADC_WIDTH`, 12: ADC sample width.
- `SLOT_WIDTH`, 16: packed slot width; must be > `ADC_WIDTH`.
- `SAMPLES_PER_WORD`, 4: slots per output word; `WORD_WIDTH = SLOT_WIDTH*SAMPLES_PER_WORD`.
- `PIPE_DELAY`, 13: ADC falling edges discarded after enable.
- `FIFO_DEPTH`, 4: output FIFO depth in words; power of two.

Ports:
- `clk_PSRAM` in 1: the block's only clock; must be ≥ 4× `clk_ADC` frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_ADC` in 1: ADC clock, sampled as data.
- `adc_out` in `ADC_WIDTH`: ADC data bus.
- `adc_OTR` in 1: ADC out-of-range bit.
- `adc_enable` in 1: capture enable, level.
- `decim` in 8: keep 1 of every `decim+1` samples; sampled on `adc_enable` rise.
- `word_data` out `WORD_WIDTH`: FIFO head word.
- `word_valid` out 1: FIFO not empty.
- `word_ready` in 1: consumer accepts the head word when high with `word_valid`.
- `fill_level` out `$clog2(FIFO_DEPTH)+1`: words held in the FIFO.
- `otr_seen` out 1: sticky; an accepted sample had OTR set.
- `overflow` out 1: sticky; a completed word was dropped.

## Operation
- `clk_ADC` passes a 2-flop synchroniser plus a previous-value register.
- A falling edge (`fe`) is previous=1, current=0; `adc_out`/`adc_OTR` are registered in the `fe` cycle.
- State machine:
  - IDLE: waiting for enable.
  - FLUSH: counting `PIPE_DELAY` `fe` events.
  - RUN: accepting samples.
- IDLE→FLUSH on `adc_enable` rise. This clears `otr_seen`, `overflow`, the flush counter, the decimation counter and the slot index, and latches `decim`.
- FLUSH→RUN on the `PIPE_DELAY`-th `fe`; that sample is discarded.
- RUN: each `fe` advances the decimation counter. A sample is accepted when the counter is 0; the counter then wraps after `decim`.
- Slot format: bit `SLOT_WIDTH-1` = OTR, bits `ADC_WIDTH-1:0` = sample, other bits 0. Slot 0 occupies the LSBs.
- After slot `SAMPLES_PER_WORD-1` is written, the word is pushed next cycle and the slot index wraps to 0.
- Push while FIFO full: word dropped, `overflow`←1, FIFO unchanged.
- Push and pop in the same cycle while full: pop first, push succeeds.
- Any state→IDLE on `adc_enable` low. The partial word is discarded; FIFO contents stay readable; sticky flags hold.
- `decim` changes outside an enable rise are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- A `clk_ADC` fall reaches `fe` 3 `clk_PSRAM` cycles later.
- Last slot of a word on `fe` cycle N: the FIFO write happens at N+1, and `word_valid` rises at N+2 if the FIFO was empty.
- `word_data` is stable while `word_valid && !word_ready`; pop happens on `word_valid && word_ready`.
- `fill_level` updates the cycle after push/pop.
- `otr_seen` is set the cycle after an accepted OTR sample.
- Reset mid-capture returns to IDLE immediately and empties the FIFO.

## Configuration
- `ADC_TEST_PATTERN_EN` defined:
  - Adds input `test_pattern` (1 bit).
  - When it is high, each accepted sample is an `ADC_WIDTH`-bit counter, and OTR is forced to 0.
  - The counter clears on `adc_enable` rise and increments per accepted sample, wrapping at 2^`ADC_WIDTH`.
- Undefined: port and counter absent; samples always come from `adc_out`.

## Structure
- Package `adc_capture_pkg` holds:
  - the state enum (IDLE, FLUSH, RUN);
  - default parameter constants;
  - the slot-format bit-position constants.
- Sub-module `adc_capture_fifo`: synchronous FIFO with `WORD_WIDTH`/`FIFO_DEPTH`, registered head output and fill count.

## Test plan
- Reset, then `adc_enable`=1, `decim`=0, `clk_ADC`=clk_PSRAM/4 with `adc_out` = edge index → first word has slots 13,14,15,16 (LSB first); `word_valid` 2 cycles after the 16th edge's `fe`.
- `decim`=2 → accepted samples 13,16,19,22 packed into one word.
- `word_ready`=0 until 5 words complete → `fill_level`=4, `overflow`=1, FIFO holds words 1–4 intact.
- `adc_OTR`=1 on edge 14 → `otr_seen`=1, slot 1 bit 15 set; the next enable rise clears `otr_seen`.
- `adc_enable` dropped after 2 slots of a word, then re-raised → partial word never appears; FLUSH repeats 13 edges.
- With `ADC_TEST_PATTERN_EN` and `test_pattern`=1 → words 0x0003_0002_0001_0000, then 0x0007_0006_0005_0004.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the ADC capture path.
// Holds the capture state enum, default parameters and the slot bit layout.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_RUN
   } state_e;

   localparam int DEF_ADC_WIDTH        = 12;
   localparam int DEF_SLOT_WIDTH       = 16;
   localparam int DEF_SAMPLES_PER_WORD = 4;
   localparam int DEF_PIPE_DELAY       = 13;
   localparam int DEF_FIFO_DEPTH       = 4;

   // Sample sits at the bottom of a slot, OTR in the top bit.
   localparam int SLOT_SAMPLE_LSB = 0;

   function automatic int slot_otr_bit(input int slot_w);
      return slot_w - 1;
   endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo: synchronous word FIFO with fill count.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, data_o/valid_o (head), count_o, drop_o.
module adc_capture_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, do_pop, do_push;

   assign full    = (cnt_q == FULL);
   assign do_pop  = pop_i & (cnt_q != '0);
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push_i & (~full | do_pop);
   assign drop_o  = push_i & full & ~do_pop;

   assign data_o  = mem_q[rp_q];
   assign valid_o = (cnt_q != '0);
   assign count_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wp_q] <= data_i;
            wp_q        <= wp_q + 1'b1;
         end
         if (do_pop) begin
            rp_q <= rp_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC edge detect, pipeline flush, decimation and word packing.
// Ports: clk_PSRAM/rst_n, clk_ADC/adc_out/adc_OTR, adc_enable/decim, word_* handshake,
// fill_level, sticky otr_seen/overflow. ADC_TEST_PATTERN_EN adds test_pattern input.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int ADC_WIDTH        = DEF_ADC_WIDTH,
   parameter int SLOT_WIDTH       = DEF_SLOT_WIDTH,
   parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
   parameter int PIPE_DELAY       = DEF_PIPE_DELAY,
   parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
   input  logic                                 clk_PSRAM,
   input  logic                                 rst_n,
   input  logic                                 clk_ADC,
   input  logic [ADC_WIDTH-1:0]                 adc_out,
   input  logic                                 adc_OTR,
   input  logic                                 adc_enable,
   input  logic [7:0]                           decim,
`ifdef ADC_TEST_PATTERN_EN
   input  logic                                 test_pattern,
`endif
   output logic [SLOT_WIDTH*SAMPLES_PER_WORD-1:0] word_data,
   output logic                                 word_valid,
   input  logic                                 word_ready,
   output logic [$clog2(FIFO_DEPTH):0]          fill_level,
   output logic                                 otr_seen,
   output logic                                 overflow
);

   localparam int WW  = SLOT_WIDTH * SAMPLES_PER_WORD;
   localparam int FLW = $clog2(PIPE_DELAY + 1);
   localparam int SIW = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
   localparam int OTR_BIT = slot_otr_bit(SLOT_WIDTH);
   localparam logic [FLW-1:0] FLUSH_LAST = FLW'(PIPE_DELAY - 1);
   localparam logic [SIW-1:0] SLOT_LAST  = SIW'(SAMPLES_PER_WORD - 1);

   logic           ck_s1_q, ck_s2_q, ck_prev_q, en_q;
   state_e         state_q, state_d;
   logic [FLW-1:0] flush_q, flush_d;
   logic [7:0]     dec_q, dec_d, decim_q, decim_d;
   logic [SIW-1:0] slot_q, slot_d;
   logic [WW-1:0]  word_q, word_d;
   logic           push_q, push_d;
   logic           otr_q, otr_d, ovf_q, ovf_d;
   logic           fe, en_rise, accept, fifo_drop, sotr;
   logic [ADC_WIDTH-1:0]  samp;
   logic [SLOT_WIDTH-1:0] slot_val;
`ifdef ADC_TEST_PATTERN_EN
   logic [ADC_WIDTH-1:0]  tp_q, tp_d;
`endif

   assign fe      = ck_prev_q & ~ck_s2_q;
   assign en_rise = adc_enable & ~en_q;

   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      dec_d    = dec_q;
      decim_d  = decim_q;
      slot_d   = slot_q;
      word_d   = word_q;
      push_d   = 1'b0;
      otr_d    = otr_q;
      ovf_d    = ovf_q | fifo_drop;
      accept   = 1'b0;
      slot_val = '0;
`ifdef ADC_TEST_PATTERN_EN
      tp_d     = tp_q;
      samp     = test_pattern ? tp_q : adc_out;
      sotr     = test_pattern ? 1'b0 : adc_OTR;
`else
      samp     = adc_out;
      sotr     = adc_OTR;
`endif
      if (!adc_enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (en_rise) begin
                  state_d = ST_FLUSH;
                  flush_d = '0;
                  dec_d   = '0;
                  slot_d  = '0;
                  decim_d = decim;
                  otr_d   = 1'b0;
                  ovf_d   = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
                  tp_d    = '0;
`endif
               end
            end
            ST_FLUSH: begin
               if (fe) begin
                  if (flush_q == FLUSH_LAST) begin
                     state_d = ST_RUN;
                     flush_d = '0;
                  end else begin
                     flush_d = flush_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (fe) begin
                  accept = (dec_q == '0);
                  dec_d  = (dec_q == decim_q) ? '0 : dec_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (accept) begin
         slot_val[SLOT_SAMPLE_LSB +: ADC_WIDTH] = samp;
         slot_val[OTR_BIT] = sotr;
         word_d[int'(slot_q)*SLOT_WIDTH +: SLOT_WIDTH] = slot_val;
         if (sotr) otr_d = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
         tp_d = tp_q + 1'b1;
`endif
         // Word is handed to the FIFO one cycle after its last slot lands.
         if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            push_d = 1'b1;
         end else begin
            slot_d = slot_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_PSRAM or negedge rst_n) begin
      if (!rst_n) begin
         ck_s1_q   <= 1'b0;
         ck_s2_q   <= 1'b0;
         ck_prev_q <= 1'b0;
         en_q      <= 1'b0;
         state_q   <= ST_IDLE;
         flush_q   <= '0;
         dec_q     <= '0;
         decim_q   <= '0;
         slot_q    <= '0;
         word_q    <= '0;
         push_q    <= 1'b0;
         otr_q     <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef ADC_TEST_PATTERN_EN
         tp_q      <= '0;
`endif
      end else begin
         ck_s1_q   <= clk_ADC;
         ck_s2_q   <= ck_s1_q;
         ck_prev_q <= ck_s2_q;
         en_q      <= adc_enable;
         state_q   <= state_d;
         flush_q   <= flush_d;
         dec_q     <= dec_d;
         decim_q   <= decim_d;
         slot_q    <= slot_d;
         word_q    <= word_d;
         push_q    <= push_d;
         otr_q     <= otr_d;
         ovf_q     <= ovf_d;
`ifdef ADC_TEST_PATTERN_EN
         tp_q      <= tp_d;
`endif
      end
   end

   adc_capture_fifo #(
      .W     (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_PSRAM),
      .rst_ni  (rst_n),
      .push_i  (push_q),
      .data_i  (word_q),
      .pop_i   (word_ready),
      .data_o  (word_data),
      .valid_o (word_valid),
      .count_o (fill_level),
      .drop_o  (fifo_drop)
   );

   assign otr_seen = otr_q;
   assign overflow = ovf_q;

endmodule
